// File: rtl/jtpopeye_objscan.sv
// Object line scanner: walks object RAM each line, packs the objects that
// intersect the next line into a double-buffered 32-slot line buffer, and
// replays the front buffer onto DJ one descriptor per 8-pixel column.
module jtpopeye_objscan #(
    parameter int unsigned OBJN = 128,
    parameter int unsigned OBJH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic [7:0]  H,
    input  logic [7:0]  V,
    input  logic        VB,
    output logic [6:0]  obj_ram_addr,
    input  logic [31:0] obj_ram_data,
    output logic [17:0] DJ
);

    // Palette 7 marks a free slot / no object for the pixel generator
    localparam logic [17:0] EMPTY    = 18'h1C000;
    localparam logic [7:0]  SCAN_BEG = 8'd32;
    localparam logic [7:0]  SCAN_END = 8'(32 + OBJN - 1);
    localparam logic [7:0]  HEIGHT   = 8'(OBJH);

    logic [17:0] r_buf [0:63];  // {wsel, slot} addressed; r_wsel picks the back half
    logic        r_wsel;
    logic [6:0]  r_addr;
    logic        r_vld;         // obj_ram_data holds a scanned entry this pxl_cen
    logic [6:0]  r_idx;         // RAM index of the entry currently on obj_ram_data
    logic [17:0] r_dj;

    logic        w_clear;
    logic        w_scan;
    logic [7:0]  w_x;
    logic [7:0]  w_y;
    logic [7:0]  w_t;
    logic [7:0]  w_d;
    logic        w_hit;
    logic [3:0]  w_row;
    logic [4:0]  w_slot;
    logic [17:0] w_desc;
    logic [17:0] w_back_cur;
    logic        w_wr_en;
    logic [4:0]  w_next_col;
    logic [17:0] w_front;
    logic        w_unused;

    // Phase decode and hit test for the entry returned by the RAM
    always_comb begin
        w_clear    = (H < SCAN_BEG);
        w_scan     = (H >= SCAN_BEG) && (H <= SCAN_END);
        w_x        = obj_ram_data[7:0];
        w_y        = obj_ram_data[15:8];
        w_t        = V + 8'd1;
        w_d        = w_t - w_y;
        w_hit      = (w_d < HEIGHT);
        w_row      = obj_ram_data[28] ? ~w_d[3:0] : w_d[3:0];
        w_slot     = w_x[7:3];
        w_desc     = {obj_ram_data[23], obj_ram_data[26:24], w_x[2:1],
                      obj_ram_data[27], obj_ram_data[22:16], w_row};
        w_back_cur = r_buf[{r_wsel, w_slot}];
        // First object to reach a slot owns it; palette-7 entries never block
        w_wr_en    = r_vld && w_hit && (w_back_cur[16:14] == 3'd7);
        w_next_col = H[7:3] + 5'd1;
        w_front    = r_buf[{~r_wsel, w_next_col}];
    end

    // Entry index is kept alongside the valid flag for visibility; X[0] and
    // the top RAM bits carry no information for the descriptor
    assign w_unused = ^{obj_ram_data[31:29], w_x[0], w_d[7:4], r_idx};

    // RAM address generation and one-stage read pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 7'd0;
            r_vld  <= 1'b0;
            r_idx  <= 7'd0;
        end else if (pxl_cen) begin
            r_addr <= w_scan ? (H[6:0] - 7'd32) : 7'd0;
            r_vld  <= w_scan;
            r_idx  <= r_addr;
        end
    end

    // Buffer swap takes effect at H=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel <= 1'b0;
        end else if (pxl_cen && (H == 8'd255)) begin
            r_wsel <= ~r_wsel;
        end
    end

    // Line buffer: clear the back half early in the line, then fill from hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                r_buf[i] <= EMPTY;
            end
        end else if (pxl_cen) begin
            if (w_clear) begin
                r_buf[{r_wsel, H[4:0]}] <= EMPTY;
            end else if (w_wr_en) begin
                r_buf[{r_wsel, w_slot}] <= w_desc;
            end
        end
    end

    // Replay: load the next column's descriptor one pixel before it is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dj <= EMPTY;
        end else if (pxl_cen && (H[2:0] == 3'd6)) begin
            r_dj <= VB ? EMPTY : w_front;
        end
    end

    assign obj_ram_addr = r_addr;
    assign DJ           = r_dj;

endmodule

// File: tb/tb_jtpopeye_objscan.sv
// Directed bench for the object line scanner: drives H/V like a video timer,
// models object RAM, and checks DJ at every H[2:0]==7 sample.
module tb_jtpopeye_objscan;

    localparam logic [17:0] EMPTY = 18'h1C000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pxl_cen;
    logic [7:0]  H;
    logic [7:0]  V;
    logic        VB;
    logic [6:0]  obj_ram_addr;
    logic [31:0] obj_ram_data;
    logic [17:0] DJ;

    logic [31:0] mem [0:127];
    logic [17:0] exp_slot [0:31];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign obj_ram_data = mem[obj_ram_addr];

    jtpopeye_objscan #(
        .OBJN (128),
        .OBJH (16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pxl_cen      (pxl_cen),
        .H            (H),
        .V            (V),
        .VB           (VB),
        .obj_ram_addr (obj_ram_addr),
        .obj_ram_data (obj_ram_data),
        .DJ           (DJ)
    );

    function automatic logic [31:0] obj(input logic [7:0] x, input logic [7:0] y,
                                        input logic [6:0] code, input logic bank,
                                        input logic [2:0] pal, input logic hf,
                                        input logic vf);
        return {3'b000, vf, hf, pal, bank, code, y, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Park every entry far away (Y=0x80) so it never hits the tested lines
    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = obj(8'h00, 8'h80, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 32; i++) exp_slot[i] = EMPTY;
    endtask

    // One pixel: a pxl_cen clock then an idle clock; H/V advance after the edge
    task automatic step();
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0;
        if (H == 8'd255) V = V + 8'd1;
        H = H + 8'd1;
        @(posedge clk);
        #1;
    endtask

    // mode 1: compare against exp_slot; mode 2: only require known values
    task automatic sample(input int mode);
        logic [4:0] s;
        if (H[2:0] == 3'd7 && H != 8'd255) begin
            s = H[7:3] + 5'd1;
            if (mode == 1) chk($sformatf("dj_v%0h_h%0h", V, H), {14'd0, DJ}, {14'd0, exp_slot[s]});
            else if (mode == 2) chk($sformatf("dj_known_v%0h_h%0h", V, H),
                                    {31'd0, $isunknown(DJ)}, 32'd0);
        end
    endtask

    task automatic run_line(input int mode);
        for (int i = 0; i < 256; i++) begin
            sample(mode);
            step();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pxl_cen = 1'b0;
        H       = 8'd0;
        V       = 8'd0;
        VB      = 1'b0;
        clear_mem();
        clear_exp();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dj", {14'd0, DJ}, {14'd0, EMPTY});
        chk("reset_addr", {25'd0, obj_ram_addr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle: two lines of EMPTY
        run_line(1);
        run_line(1);

        // Single hit, slot 5: bank1 pal3 X[2:1]=0 hflip code 0x15 row 4
        V = 8'h13;
        mem[5] = obj(8'h28, 8'h10, 7'h15, 1'b1, 3'd3, 1'b1, 1'b0);
        run_line(0);
        exp_slot[5] = 18'h2C954;
        run_line(1);

        // Same with vflip: row = ~4 = 0xB
        V = 8'h13;
        mem[5] = obj(8'h28, 8'h10, 7'h15, 1'b1, 3'd3, 1'b1, 1'b1);
        run_line(0);
        clear_exp();
        exp_slot[5] = 18'h2C95B;
        run_line(1);

        // Slot priority: palette-7 entry 1 does not block entry 2; entry 9 is dropped
        clear_mem();
        mem[1] = obj(8'h21, 8'h40, 7'h7F, 1'b0, 3'd7, 1'b0, 1'b0);
        mem[2] = obj(8'h20, 8'h40, 7'h01, 1'b0, 3'd1, 1'b0, 1'b0);
        mem[3] = obj(8'h41, 8'h40, 7'h7F, 1'b0, 3'd7, 1'b0, 1'b0);
        mem[9] = obj(8'h22, 8'h42, 7'h02, 1'b1, 3'd2, 1'b1, 1'b0);
        V = 8'h44;
        run_line(0);
        clear_exp();
        exp_slot[4] = 18'h04015;
        exp_slot[8] = 18'h1C7F5;
        run_line(1);

        // Entry 9 moved to slot 6 now shows up
        mem[9] = obj(8'h30, 8'h42, 7'h02, 1'b1, 3'd2, 1'b1, 1'b0);
        V = 8'h44;
        run_line(0);
        exp_slot[6] = 18'h28823;
        run_line(1);

        // Y wrap: Y=0xFA, T=4 -> d=10 hit
        clear_mem();
        mem[20] = obj(8'h0F, 8'hFA, 7'h7F, 1'b0, 3'd5, 1'b0, 1'b0);
        V = 8'h03;
        run_line(0);
        clear_exp();
        exp_slot[1] = 18'h177FA;
        run_line(1);

        // T=0x0B -> d=17, no hit
        V = 8'h0A;
        run_line(0);
        clear_exp();
        run_line(1);

        // VB forces EMPTY, but the line scanned during VB is valid afterwards
        clear_mem();
        mem[5] = obj(8'h28, 8'h10, 7'h15, 1'b1, 3'd3, 1'b1, 1'b0);
        V  = 8'h12;
        VB = 1'b1;
        run_line(0);
        clear_exp();
        run_line(1);
        VB = 1'b0;
        exp_slot[5] = 18'h2C954;
        run_line(1);

        // Mid-line reset while DJ holds a live descriptor
        clear_mem();
        mem[30] = obj(8'h50, 8'h60, 7'h33, 1'b1, 3'd6, 1'b0, 1'b1);
        V = 8'h62;
        run_line(0);
        clear_exp();
        exp_slot[10] = 18'h3833C;
        while (H != 8'h50) begin
            sample(1);
            step();
        end
        chk("pre_reset_dj", {14'd0, DJ}, {14'd0, 18'h3833C});
        rst_n = 1'b0;
        #1;
        chk("async_reset_dj", {14'd0, DJ}, {14'd0, EMPTY});
        chk("async_reset_addr", {25'd0, obj_ram_addr}, 32'd0);
        step();
        rst_n = 1'b1;
        while (H != 8'h00) begin
            sample(2);
            step();
        end
        run_line(2);
        clear_exp();
        exp_slot[10] = 18'h3833A;
        run_line(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
